// File: rtl/bure_fetch_queue_if.sv
// Instruction/data memory port bundle; the fetch stage uses only the read side.
interface cg_memory_interface #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  raddr_valid;
  logic                  raddr_ready;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  rdata_valid;
  logic                  rdata_ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wen;
  logic                  wdata_valid;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  modport to_memory (
    output raddr_valid, raddr, rdata_ready, wen, wdata_valid, waddr, wdata,
    input  raddr_ready, rdata_valid, rdata
  );
endinterface

// File: rtl/bure_fetch_queue.sv
// Instruction fetch stage: keeps several reads in flight, buffers returned
// instructions with their PCs in a FIFO, and drops stale data after a redirect.
module bure_fetch_queue #(
  parameter int unsigned          ADDR_WIDTH      = 32,
  parameter int unsigned          INSTR_WIDTH     = 32,
  parameter int unsigned          DATA_WIDTH      = 32,
  parameter int unsigned          DEPTH           = 4,
  parameter int unsigned          MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  cg_memory_interface.to_memory        if_imem,
  input  logic                         i_redirect,
  input  logic [ADDR_WIDTH-1:0]        i_redirect_pc,
  output logic                         o_instr_valid,
  output logic [INSTR_WIDTH-1:0]       o_instr,
  output logic [ADDR_WIDTH-1:0]        o_pc,
  input  logic                         i_instr_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_level
);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW = LW + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INSTR_WIDTH / 8);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t                 r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_req_pc, r_rsp_pc;
  logic [OW-1:0]          r_out_cnt, r_drop_cnt, w_out_after_rsp;
  logic [LW-1:0]          r_level;
  logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [INSTR_WIDTH-1:0] r_mem_instr [DEPTH];
  logic [ADDR_WIDTH-1:0]  r_mem_pc    [DEPTH];
  logic [DATA_WIDTH-1:0]  w_rdata;
  logic                   w_raddr_valid, w_issue, w_rsp, w_redirect, w_push, w_pop;

  assign w_rdata         = if_imem.rdata;
  assign w_redirect      = i_redirect & (r_state != S_IDLE);
  assign w_rsp           = if_imem.rdata_valid & (r_out_cnt != '0);
  assign w_issue         = w_raddr_valid & if_imem.raddr_ready;
  assign w_push          = w_rsp & (r_state == S_FETCH) & ~w_redirect;
  assign w_pop           = o_instr_valid & i_instr_ready & ~w_redirect;
  assign w_out_after_rsp = r_out_cnt - OW'(w_rsp);

  assign if_imem.raddr_valid = w_raddr_valid;
  assign if_imem.raddr       = r_req_pc;
  assign if_imem.rdata_ready = 1'b1;
  assign if_imem.wen         = 1'b0;
  assign if_imem.wdata_valid = 1'b0;
  assign if_imem.waddr       = '0;
  assign if_imem.wdata       = '0;

  assign o_instr_valid = (r_level != '0);
  assign o_instr       = r_mem_instr[r_rd_ptr];
  assign o_pc          = r_mem_pc[r_rd_ptr];
  assign o_level       = r_level;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Requests only go out when both an in-flight slot and FIFO credit exist.
  always_comb begin
    w_state_nxt   = r_state;
    w_raddr_valid = 1'b0;
    unique case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: w_raddr_valid = ~i_redirect
                             & (r_out_cnt < OW'(MAX_OUTSTANDING))
                             & ((SW'(r_level) + SW'(r_out_cnt)) < SW'(DEPTH));
      S_DRAIN: if (w_rsp && (r_drop_cnt == OW'(1))) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_redirect) w_state_nxt = (w_out_after_rsp != '0) ? S_DRAIN : S_FETCH;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_req_pc   <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_out_cnt <= w_out_after_rsp + OW'(w_issue);
      if (w_redirect) begin
        r_req_pc   <= i_redirect_pc;
        r_rsp_pc   <= i_redirect_pc;
        r_drop_cnt <= w_out_after_rsp;
      end else begin
        if (w_issue) r_req_pc <= r_req_pc + STEP;
        if (w_push)  r_rsp_pc <= r_rsp_pc + STEP;
        if (w_rsp && (r_state == S_DRAIN)) r_drop_cnt <= r_drop_cnt - OW'(1);
      end
    end
  end

  // Prefetch FIFO; a redirect empties it and overrides any pop in that cycle.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= RESET_PC;
      end
    end else if (w_redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem_instr[r_wr_ptr] <= INSTR_WIDTH'(w_rdata);
        r_mem_pc[r_wr_ptr]    <= r_rsp_pc;
        r_wr_ptr              <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);
    end
  end
endmodule

// File: tb/tb_bure_fetch_queue.sv
// Bench for bure_fetch_queue: directed scenarios plus random traffic against a
// transaction-level model (tagged in-flight queue + instruction FIFO queue).
module tb_bure_fetch_queue;
  localparam int unsigned AW = 32, IW = 32, DEPTH = 4, MAXO = 2;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rstn, redirect, instr_ready, instr_valid;
  logic [31:0] redirect_pc, instr, pc;
  logic [2:0]  level;

  cg_memory_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(IW)) imem ();

  bure_fetch_queue #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DATA_WIDTH(IW),
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .if_imem(imem),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_instr_valid(instr_valid), .o_instr(instr), .o_pc(pc),
    .i_instr_ready(instr_ready), .o_level(level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int unsigned p_rready, p_rvalid, p_iready;
  bit stray;

  logic [31:0] mq[$];
  bit          cur_redir, cur_mem_rsp, act_issue;
  logic [31:0] cur_rpc, act_raddr;

  bit          m_started;
  logic [31:0] m_pc;
  logic [31:0] f_pc[$], f_ins[$], o_pcq[$];
  bit          o_live[$];

  bit          e_rv, e_ov;
  logic [31:0] e_raddr, e_opc, e_oins;
  int          e_level;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Apply this cycle's inputs and derive the model's expected outputs.
  task automatic drive(input bit redir, input logic [31:0] rpc);
    bit stale;
    cur_redir   = redir;
    cur_rpc     = rpc;
    redirect    = redir;
    redirect_pc = rpc;
    imem.raddr_ready = ($urandom_range(99) < p_rready);
    instr_ready      = ($urandom_range(99) < p_iready);
    cur_mem_rsp = (mq.size() > 0) && ($urandom_range(99) < p_rvalid);
    if (cur_mem_rsp) begin
      imem.rdata_valid = 1'b1; imem.rdata = mem_word(mq[0]);
    end else if (stray) begin
      imem.rdata_valid = 1'b1; imem.rdata = 32'hDEAD_BEEF;
    end else begin
      imem.rdata_valid = 1'b0; imem.rdata = '0;
    end
    #1;
    act_issue = imem.raddr_valid && imem.raddr_ready;
    act_raddr = imem.raddr;
    stale = 1'b0;
    foreach (o_live[k]) if (!o_live[k]) stale = 1'b1;
    e_rv    = m_started && !redir && !stale && (o_live.size() < MAXO)
              && (f_pc.size() + o_live.size() < DEPTH);
    e_raddr = m_pc;
    e_ov    = (f_pc.size() > 0);
    e_opc   = e_ov ? f_pc[0] : RPC;
    e_oins  = e_ov ? f_ins[0] : '0;
    e_level = f_pc.size();
  endtask

  // Commit this cycle to the model and memory, then advance one clock.
  task automatic tick();
    bit rsp, redir_eff, pop, live;
    logic [31:0] rp;
    rsp       = imem.rdata_valid && (o_live.size() > 0);
    redir_eff = m_started && cur_redir;
    pop       = (f_pc.size() > 0) && instr_ready && !redir_eff;
    if (pop) begin void'(f_pc.pop_front()); void'(f_ins.pop_front()); end
    if (rsp) begin
      live = o_live.pop_front();
      rp   = o_pcq.pop_front();
      if (live && !redir_eff) begin f_pc.push_back(rp); f_ins.push_back(mem_word(rp)); end
    end
    if (e_rv && imem.raddr_ready) begin
      o_live.push_back(1'b1); o_pcq.push_back(m_pc); m_pc = m_pc + 32'd4;
    end
    if (redir_eff) begin
      f_pc.delete(); f_ins.delete();
      foreach (o_live[k]) o_live[k] = 1'b0;
      m_pc = cur_rpc;
    end
    m_started = 1'b1;
    if (cur_mem_rsp) void'(mq.pop_front());
    if (act_issue) mq.push_back(act_raddr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic assert_reset();
    rstn = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    imem.raddr_ready = 1'b0; imem.rdata_valid = 1'b0; imem.rdata = '0; stray = 1'b0;
    mq.delete(); f_pc.delete(); f_ins.delete(); o_live.delete(); o_pcq.delete();
    m_started = 1'b0; m_pc = RPC;
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic reset_dut();
    assert_reset();
    release_reset();
  endtask

  task automatic test_reset();
    assert_reset();
    @(negedge clk); #1;
    n_cmp++; if (imem.raddr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got %0b want 0", imem.raddr_valid); end
    n_cmp++; if (imem.raddr !== RPC) begin n_fail++; $display("FAIL reset_raddr got %h want %h", imem.raddr, RPC); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ov got %0b want 0", instr_valid); end
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", instr); end
    n_cmp++; if (pc !== RPC) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc, RPC); end
    release_reset();
    p_rready = 100; p_rvalid = 100; p_iready = 100; stray = 1'b1;
    drive(1'b1, 32'h5000);
    n_cmp++; if (imem.raddr_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rv got %0b want 0", imem.raddr_valid); end
    tick();
    stray = 1'b0;
    drive(1'b0, '0);
    n_cmp++; if (imem.raddr_valid !== 1'b1) begin n_fail++; $display("FAIL first_rv got %0b want 1", imem.raddr_valid); end
    n_cmp++; if (imem.raddr !== RPC) begin n_fail++; $display("FAIL first_raddr got %h want %h", imem.raddr, RPC); end
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL stray_level got %0d want 0", level); end
    tick();
  endtask

  task automatic test_stream();
    reset_dut();
    p_rready = 100; p_rvalid = 100; p_iready = 100;
    for (int c = 0; c < 16; c++) begin
      drive(1'b0, '0);
      if (c == 0) begin
        n_cmp++; if (imem.raddr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle_rv c%0d got %0b want 0", c, imem.raddr_valid); end
      end else begin
        n_cmp++; if (imem.raddr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_rv c%0d got %0b want 1", c, imem.raddr_valid); end
        n_cmp++; if (imem.raddr !== RPC + 32'(4 * (c - 1))) begin n_fail++; $display("FAIL stream_raddr c%0d got %h want %h", c, imem.raddr, RPC + 32'(4 * (c - 1))); end
      end
      if (c >= 3) begin
        n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_ov c%0d got %0b want 1", c, instr_valid); end
        n_cmp++; if (pc !== RPC + 32'(4 * (c - 3))) begin n_fail++; $display("FAIL stream_pc c%0d got %h want %h", c, pc, RPC + 32'(4 * (c - 3))); end
        n_cmp++; if (instr !== mem_word(RPC + 32'(4 * (c - 3)))) begin n_fail++; $display("FAIL stream_instr c%0d got %h want %h", c, instr, mem_word(RPC + 32'(4 * (c - 3)))); end
      end
      tick();
    end
  endtask

  task automatic test_full();
    int n;
    reset_dut();
    p_rready = 100; p_rvalid = 100; p_iready = 0; n = 0;
    repeat (12) begin drive(1'b0, '0); if (act_issue) n++; tick(); end
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL full_issues got %0d want 4", n); end
    p_iready = 100;
    drive(1'b0, '0);
    n_cmp++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_level got %0d want 4", level); end
    n_cmp++; if (imem.raddr_valid !== 1'b0) begin n_fail++; $display("FAIL full_rv_pop_cycle got %0b want 0", imem.raddr_valid); end
    n_cmp++; if (pc !== RPC) begin n_fail++; $display("FAIL full_head_pc got %h want %h", pc, RPC); end
    tick();
    p_iready = 0;
    drive(1'b0, '0);
    n_cmp++; if (level !== 3'd3) begin n_fail++; $display("FAIL full_level_after_pop got %0d want 3", level); end
    n_cmp++; if (imem.raddr_valid !== 1'b1) begin n_fail++; $display("FAIL full_credit_rv got %0b want 1", imem.raddr_valid); end
    n_cmp++; if (imem.raddr !== RPC + 32'h10) begin n_fail++; $display("FAIL full_credit_raddr got %h want %h", imem.raddr, RPC + 32'h10); end
    tick();
    drive(1'b0, '0);
    n_cmp++; if (imem.raddr_valid !== 1'b0) begin n_fail++; $display("FAIL full_refill_rv got %0b want 0", imem.raddr_valid); end
    tick();
    drive(1'b0, '0);
    n_cmp++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_refill_level got %0d want 4", level); end
    tick();
  endtask

  task automatic test_redirect_outstanding();
    bit seen;
    reset_dut();
    p_rready = 100; p_iready = 0; p_rvalid = 100;
    repeat (3) begin drive(1'b0, '0); tick(); end
    p_rvalid = 0;
    drive(1'b0, '0); tick();
    drive(1'b0, '0);
    n_cmp++; if (imem.raddr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_pre_rv got %0b want 0", imem.raddr_valid); end
    n_cmp++; if (level !== 3'd1) begin n_fail++; $display("FAIL redir_pre_level got %0d want 1", level); end
    tick();
    drive(1'b1, 32'h2000); tick();
    p_rvalid = 100; p_iready = 100;
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, '0);
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drain_ov c%0d got %0b want 0", c, instr_valid); end
      n_cmp++; if (imem.raddr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drain_rv c%0d got %0b want 0", c, imem.raddr_valid); end
      n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL redir_drain_level c%0d got %0d want 0", c, level); end
      tick();
    end
    drive(1'b0, '0);
    n_cmp++; if (imem.raddr_valid !== 1'b1) begin n_fail++; $display("FAIL redir_restart_rv got %0b want 1", imem.raddr_valid); end
    n_cmp++; if (imem.raddr !== 32'h2000) begin n_fail++; $display("FAIL redir_restart_raddr got %h want 2000", imem.raddr); end
    tick();
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      drive(1'b0, '0);
      if (instr_valid) begin
        seen = 1'b1;
        n_cmp++; if (pc !== 32'h2000) begin n_fail++; $display("FAIL redir_first_pc got %h want 2000", pc); end
        n_cmp++; if (instr !== mem_word(32'h2000)) begin n_fail++; $display("FAIL redir_first_instr got %h want %h", instr, mem_word(32'h2000)); end
      end
      tick();
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL redir_first_timeout got none want valid at 2000"); end
  endtask

  task automatic test_redirect_fifo();
    reset_dut();
    p_rready = 100; p_rvalid = 100; p_iready = 0;
    repeat (4) begin drive(1'b0, '0); tick(); end
    p_rready = 0;
    drive(1'b0, '0); tick();
    drive(1'b1, 32'h3000);
    n_cmp++; if (level !== 3'd3) begin n_fail++; $display("FAIL rfifo_pre_level got %0d want 3", level); end
    tick();
    drive(1'b0, '0);
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL rfifo_level got %0d want 0", level); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rfifo_ov got %0b want 0", instr_valid); end
    n_cmp++; if (imem.raddr_valid !== 1'b1) begin n_fail++; $display("FAIL rfifo_rv got %0b want 1", imem.raddr_valid); end
    n_cmp++; if (imem.raddr !== 32'h3000) begin n_fail++; $display("FAIL rfifo_raddr got %h want 3000", imem.raddr); end
    tick();
  endtask

  task automatic test_raddr_stall();
    reset_dut();
    p_rready = 0; p_rvalid = 100; p_iready = 100;
    drive(1'b0, '0); tick();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, '0);
      n_cmp++; if (imem.raddr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_rv c%0d got %0b want 1", c, imem.raddr_valid); end
      n_cmp++; if (imem.raddr !== RPC) begin n_fail++; $display("FAIL stall_raddr c%0d got %h want %h", c, imem.raddr, RPC); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_ov c%0d got %0b want 0", c, instr_valid); end
      tick();
    end
    p_rready = 100;
    drive(1'b0, '0); tick();
    drive(1'b0, '0);
    n_cmp++; if (imem.raddr !== RPC + 32'd4) begin n_fail++; $display("FAIL stall_resume_raddr got %h want %h", imem.raddr, RPC + 32'd4); end
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    logic [31:0] iss[$], pops[$];
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    reset_dut();
    p_rready = 100; p_rvalid = 100; p_iready = 100;
    repeat (3) begin drive(1'b0, '0); tick(); end
    drive(1'b1, 32'hFFFF_FFF8); tick();
    for (int c = 0; c < 20 && pops.size() < 3; c++) begin
      drive(1'b0, '0);
      if (act_issue) iss.push_back(act_raddr);
      if (instr_valid && instr_ready) begin
        pops.push_back(pc);
        n_cmp++; if (instr !== mem_word(pc)) begin n_fail++; $display("FAIL wrap_instr got %h want %h", instr, mem_word(pc)); end
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (iss.size() <= k) begin n_fail++; $display("FAIL wrap_issue%0d got none want %h", k, want[k]); end
      else if (iss[k] !== want[k]) begin n_fail++; $display("FAIL wrap_issue%0d got %h want %h", k, iss[k], want[k]); end
      n_cmp++;
      if (pops.size() <= k) begin n_fail++; $display("FAIL wrap_pc%0d got none want %h", k, want[k]); end
      else if (pops[k] !== want[k]) begin n_fail++; $display("FAIL wrap_pc%0d got %h want %h", k, pops[k], want[k]); end
    end
  endtask

  task automatic test_reset_mid_drain();
    reset_dut();
    p_rready = 100; p_iready = 0; p_rvalid = 100;
    repeat (3) begin drive(1'b0, '0); tick(); end
    p_rvalid = 0;
    repeat (2) begin drive(1'b0, '0); tick(); end
    drive(1'b1, 32'h4000); tick();
    assert_reset();
    #1;
    n_cmp++; if (imem.raddr_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_rv got %0b want 0", imem.raddr_valid); end
    n_cmp++; if (imem.raddr !== RPC) begin n_fail++; $display("FAIL mrst_raddr got %h want %h", imem.raddr, RPC); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_ov got %0b want 0", instr_valid); end
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL mrst_level got %0d want 0", level); end
    n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL mrst_instr got %h want 0", instr); end
    n_cmp++; if (pc !== RPC) begin n_fail++; $display("FAIL mrst_pc got %h want %h", pc, RPC); end
    release_reset();
    p_rvalid = 100; p_iready = 100; stray = 1'b1;
    drive(1'b0, '0); tick();
    stray = 1'b0;
    drive(1'b0, '0);
    n_cmp++; if (imem.raddr !== RPC) begin n_fail++; $display("FAIL mrst_restart_raddr got %h want %h", imem.raddr, RPC); end
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL mrst_stray_level got %0d want 0", level); end
    tick();
  endtask

  task automatic test_random();
    bit redir;
    logic [31:0] rpc;
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        p_rready = $urandom_range(100, 30);
        p_rvalid = $urandom_range(100, 30);
        p_iready = $urandom_range(100, 20);
      end
      redir = ($urandom_range(99) < 3);
      rpc   = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      drive(redir, rpc);
      n_cmp++; if (imem.raddr_valid !== e_rv) begin n_fail++; $display("FAIL rand_rv c%0d got %0b want %0b", c, imem.raddr_valid, e_rv); end
      n_cmp++; if (imem.raddr !== e_raddr) begin n_fail++; $display("FAIL rand_raddr c%0d got %h want %h", c, imem.raddr, e_raddr); end
      n_cmp++; if (instr_valid !== e_ov) begin n_fail++; $display("FAIL rand_ov c%0d got %0b want %0b", c, instr_valid, e_ov); end
      n_cmp++; if (level !== 3'(e_level)) begin n_fail++; $display("FAIL rand_level c%0d got %0d want %0d", c, level, e_level); end
      if (e_ov) begin
        n_cmp++; if (pc !== e_opc) begin n_fail++; $display("FAIL rand_pc c%0d got %h want %h", c, pc, e_opc); end
        n_cmp++; if (instr !== e_oins) begin n_fail++; $display("FAIL rand_instr c%0d got %h want %h", c, instr, e_oins); end
      end
      tick();
    end
  endtask

  initial begin
    p_rready = 100; p_rvalid = 100; p_iready = 100;
    test_reset();
    test_stream();
    test_full();
    test_redirect_outstanding();
    test_redirect_fifo();
    test_raddr_stall();
    test_wrap();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
